// File: rtl/usb_decode.sv
// USB packet decoder: classifies received packets by PID, checks token CRC5 and
// data CRC16, and forwards data payload with the two trailing CRC bytes stripped.
module usb_decode (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_tvalid_i,
    input  logic       rx_tlast_i,
    input  logic [7:0] rx_tdata_i,
    output logic       rx_tready_o,
    output logic       hsk_recv_o,
    output logic [1:0] hsk_type_o,
    output logic       tok_recv_o,
    output logic [1:0] tok_type_o,
    output logic [6:0] tok_addr_o,
    output logic [3:0] tok_endp_o,
    output logic       trn_start_o,
    output logic [1:0] trn_type_o,
    output logic       out_tvalid_o,
    output logic       out_tlast_o,
    output logic [7:0] out_tdata_o,
    output logic       trn_done_o,
    output logic       trn_crc_err_o
);

    typedef enum logic [2:0] {IDLE, TOK1, TOK2, DATA, DROP} state_t;

    // Serial USB CRCs, bits taken LSB-first from each byte.
    function automatic logic [4:0] crc5_step(input logic [4:0] cur, input logic [7:0] data);
        logic [4:0] c;
        c = cur;
        for (int i = 0; i < 8; i++) begin
            if (data[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
            else                c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] cur, input logic [7:0] data);
        logic [15:0] c;
        c = cur;
        for (int i = 0; i < 8; i++) begin
            if (data[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    state_t      state;
    logic [4:0]  crc5_q;
    logic [15:0] crc16_q;
    logic [1:0]  tok_type_pend;
    logic [7:0]  tok_byte1;
    logic [7:0]  line0;
    logic [7:0]  line1;
    logic [1:0]  fill;
    logic        done_pending;

    logic        pid_ok;
    logic [4:0]  crc5_next;
    logic [15:0] crc16_next;

    assign pid_ok     = (rx_tdata_i[7:4] == ~rx_tdata_i[3:0]);
    assign crc5_next  = crc5_step(crc5_q, rx_tdata_i);
    assign crc16_next = crc16_step(crc16_q, rx_tdata_i);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rx_tready_o   <= 1'b0;
            hsk_recv_o    <= 1'b0;
            hsk_type_o    <= 2'b00;
            tok_recv_o    <= 1'b0;
            tok_type_o    <= 2'b00;
            tok_addr_o    <= 7'd0;
            tok_endp_o    <= 4'd0;
            trn_start_o   <= 1'b0;
            trn_type_o    <= 2'b00;
            out_tvalid_o  <= 1'b0;
            out_tlast_o   <= 1'b0;
            out_tdata_o   <= 8'd0;
            trn_done_o    <= 1'b0;
            trn_crc_err_o <= 1'b0;
            crc5_q        <= 5'h1F;
            crc16_q       <= 16'hFFFF;
            tok_type_pend <= 2'b00;
            tok_byte1     <= 8'd0;
            line0         <= 8'd0;
            line1         <= 8'd0;
            fill          <= 2'd0;
            done_pending  <= 1'b0;
        end else begin
            rx_tready_o  <= 1'b1;
            hsk_recv_o   <= 1'b0;
            tok_recv_o   <= 1'b0;
            trn_start_o  <= 1'b0;
            trn_done_o   <= 1'b0;
            out_tvalid_o <= 1'b0;
            out_tlast_o  <= 1'b0;
            done_pending <= 1'b0;

            // A data PID that was itself the last byte finishes one cycle after its start pulse.
            if (done_pending) begin
                trn_done_o    <= 1'b1;
                trn_crc_err_o <= 1'b1;
            end

            if (rx_tvalid_i) begin
                case (state)
                    IDLE: begin
                        if (!pid_ok) begin
                            state <= rx_tlast_i ? IDLE : DROP;
                        end else begin
                            case (rx_tdata_i[1:0])
                                2'b10: begin
                                    if (rx_tlast_i) begin
                                        hsk_recv_o <= 1'b1;
                                        hsk_type_o <= rx_tdata_i[3:2];
                                    end else begin
                                        state <= DROP;
                                    end
                                end
                                2'b01: begin
                                    tok_type_pend <= rx_tdata_i[3:2];
                                    crc5_q        <= 5'h1F;
                                    state         <= rx_tlast_i ? IDLE : TOK1;
                                end
                                2'b11: begin
                                    trn_start_o <= 1'b1;
                                    trn_type_o  <= rx_tdata_i[3:2];
                                    crc16_q     <= 16'hFFFF;
                                    fill        <= 2'd0;
                                    if (rx_tlast_i) done_pending <= 1'b1;
                                    else            state        <= DATA;
                                end
                                default: begin
                                    state <= rx_tlast_i ? IDLE : DROP;
                                end
                            endcase
                        end
                    end
                    TOK1: begin
                        tok_byte1 <= rx_tdata_i;
                        crc5_q    <= crc5_next;
                        state     <= rx_tlast_i ? IDLE : TOK2;
                    end
                    TOK2: begin
                        if (rx_tlast_i) begin
                            state <= IDLE;
                            if (crc5_next == 5'h0C) begin
                                tok_recv_o <= 1'b1;
                                tok_type_o <= tok_type_pend;
                                tok_addr_o <= tok_byte1[6:0];
                                tok_endp_o <= {rx_tdata_i[2:0], tok_byte1[7]};
                            end
                        end else begin
                            state <= DROP;
                        end
                    end
                    DATA: begin
                        crc16_q <= crc16_next;
                        // The last two bytes seen are held back since they may turn out to be the CRC.
                        if (fill == 2'd2) begin
                            out_tvalid_o <= 1'b1;
                            out_tdata_o  <= line0;
                            line0        <= line1;
                            line1        <= rx_tdata_i;
                        end else if (fill == 2'd1) begin
                            line1 <= rx_tdata_i;
                            fill  <= 2'd2;
                        end else begin
                            line0 <= rx_tdata_i;
                            fill  <= 2'd1;
                        end
                        if (rx_tlast_i) begin
                            out_tlast_o   <= (fill == 2'd2);
                            trn_done_o    <= 1'b1;
                            trn_crc_err_o <= (fill == 2'd0) || (crc16_next != 16'h800D);
                            fill          <= 2'd0;
                            state         <= IDLE;
                        end
                    end
                    DROP: begin
                        if (rx_tlast_i) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
